// File: rtl/hive_stack_err_if.sv
// Bundles the stack-error, readback, clear, counter and interrupt signals of
// hive_stack_err. The clock and reset remain separate ports on the module.
//
// Signals (the directions shown are as seen by the slave, hive_stack_err):
//   id_2_i      in   THD_W    thread ID at stage 2
//   pop_er_2_i  in   STK_N    pop-when-empty strobes for id_2_i
//   id_6_i      in   THD_W    thread ID at stage 6
//   psh_er_6_i  in   STK_N    push-when-full strobes for id_6_i
//   en_i        in   THD_N    per-thread interrupt enable
//   rd_id_i     in   THD_W    readback thread select
//   rd_data_o   out  2*STK_N  {psh, pop} flags of the selected thread
//   clr_i       in   1        clear strobe
//   clr_id_i    in   THD_W    thread to clear
//   clr_msk_i   in   2*STK_N  write-one-to-clear mask, {psh, pop} layout
//   cnt_clr_i   in   1        error counter clear
//   cnt_o       out  CNT_W    saturating error event count
//   irq_o       out  THD_N    per-thread interrupt request
interface hive_stack_err_if #(
    parameter int unsigned THD_W = 3,
    parameter int unsigned STK_N = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned THD_N = 1 << THD_W;

    logic [THD_W-1:0]   id_2_i;
    logic [STK_N-1:0]   pop_er_2_i;
    logic [THD_W-1:0]   id_6_i;
    logic [STK_N-1:0]   psh_er_6_i;
    logic [THD_N-1:0]   en_i;
    logic [THD_W-1:0]   rd_id_i;
    logic [2*STK_N-1:0] rd_data_o;
    logic               clr_i;
    logic [THD_W-1:0]   clr_id_i;
    logic [2*STK_N-1:0] clr_msk_i;
    logic               cnt_clr_i;
    logic [CNT_W-1:0]   cnt_o;
    logic [THD_N-1:0]   irq_o;

    // Stimulus side (the stack pipeline and the register host).
    modport master (
        output id_2_i, pop_er_2_i, id_6_i, psh_er_6_i, en_i, rd_id_i,
        output clr_i, clr_id_i, clr_msk_i, cnt_clr_i,
        input  rd_data_o, cnt_o, irq_o
    );

    // Error collector side.
    modport slave (
        input  id_2_i, pop_er_2_i, id_6_i, psh_er_6_i, en_i, rd_id_i,
        input  clr_i, clr_id_i, clr_msk_i, cnt_clr_i,
        output rd_data_o, cnt_o, irq_o
    );
endinterface

// File: rtl/hive_stack_err.sv
// Collects the Hive stack LIFO error strobes. It keeps sticky per-thread,
// per-stack pop/push error flags and a saturating count of error events, and it
// raises per-thread interrupts. The flags are read back through a registered
// port and cleared by write-one-to-clear.
//
// Ports:
//   clk_i  in  clock
//   rst_i  in  asynchronous active-low reset
//   bus    hive_stack_err_if.slave  (error strobes, readback, clear, counter, irq)
//
// All outputs are registered, so no input reaches an output combinationally.
module hive_stack_err #(
    parameter int unsigned THD_W = 3,
    parameter int unsigned STK_N = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic            clk_i,
    input logic            rst_i,
    hive_stack_err_if.slave bus
);
    localparam int unsigned THD_N = 1 << THD_W;
    localparam int unsigned FLG_W = 2 * STK_N;

    typedef struct packed {
        logic [THD_N-1:0][STK_N-1:0] psh;
        logic [THD_N-1:0][STK_N-1:0] pop;
    } flg_t;

    flg_t             flg_q, flg_d;
    logic [FLG_W-1:0] rd_q, rd_d;
    logic [THD_N-1:0] irq_q, irq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear masks are split into the pop and push halves and gated by clr_i.
    logic [STK_N-1:0] pop_clr_msk, psh_clr_msk;

    assign pop_clr_msk = bus.clr_i ? bus.clr_msk_i[STK_N-1:0]     : '0;
    assign psh_clr_msk = bus.clr_i ? bus.clr_msk_i[FLG_W-1:STK_N] : '0;

    // Flag next state. The clear is applied first and the set after it, so an
    // error arriving in the same cycle as its clear leaves the flag at 1.
    always_comb begin
        flg_d = flg_q;
        flg_d.pop[bus.clr_id_i] = flg_d.pop[bus.clr_id_i] & ~pop_clr_msk;
        flg_d.psh[bus.clr_id_i] = flg_d.psh[bus.clr_id_i] & ~psh_clr_msk;
        // Both sources may name the same thread. Each one ORs into its own half.
        flg_d.pop[bus.id_2_i] = flg_d.pop[bus.id_2_i] | bus.pop_er_2_i;
        flg_d.psh[bus.id_6_i] = flg_d.psh[bus.id_6_i] | bus.psh_er_6_i;
    end

    // The interrupt is taken from the next state, so it rises on the same edge
    // as the flag and falls on the edge that clears the last flag.
    always_comb begin
        irq_d = '0;
        for (int unsigned t = 0; t < THD_N; t++) begin
            irq_d[t] = bus.en_i[t] & ((|flg_d.pop[t]) | (|flg_d.psh[t]));
        end
    end

    // The readback samples the current flag register and not the next state.
    assign rd_d = {flg_q.psh[bus.rd_id_i], flg_q.pop[bus.rd_id_i]};

    // Event counter. inc counts every strobe bit, including bits on flags that
    // are already set. The sum has two extra bits so it cannot wrap before the
    // saturation compare.
    logic [CNT_W:0]   inc;
    logic [CNT_W+1:0] cnt_base;
    logic [CNT_W+1:0] cnt_sum;

    localparam logic [CNT_W+1:0] CntMax = {2'b00, {CNT_W{1'b1}}};

    always_comb begin
        inc = '0;
        for (int unsigned s = 0; s < STK_N; s++) begin
            inc = inc + (CNT_W+1)'(bus.pop_er_2_i[s]) + (CNT_W+1)'(bus.psh_er_6_i[s]);
        end
    end

    // A counter clear restarts from zero but keeps the events of this cycle.
    assign cnt_base = bus.cnt_clr_i ? '0 : {2'b00, cnt_q};
    assign cnt_sum  = cnt_base + {1'b0, inc};
    assign cnt_d    = (cnt_sum > CntMax) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flg_q <= '0;
            rd_q  <= '0;
            irq_q <= '0;
            cnt_q <= '0;
        end else begin
            flg_q <= flg_d;
            rd_q  <= rd_d;
            irq_q <= irq_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.rd_data_o = rd_q;
    assign bus.irq_o     = irq_q;
    assign bus.cnt_o     = cnt_q;

endmodule

// File: tb/tb_hive_stack_err.sv
module tb_hive_stack_err;
    localparam int unsigned THD_W = 3;
    localparam int unsigned STK_N = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned THD_N = 1 << THD_W;

    logic clk;
    logic rst;

    hive_stack_err_if #(.THD_W(THD_W), .STK_N(STK_N), .CNT_W(CNT_W)) bus_if ();

    hive_stack_err #(.THD_W(THD_W), .STK_N(STK_N), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] irq;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the register state.
    logic [3:0] m_pop [THD_N];
    logic [3:0] m_psh [THD_N];
    logic [7:0] m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < THD_N; t++) begin
            m_pop[t] = '0;
            m_psh[t] = '0;
        end
        m_cnt = '0;
    endtask

    // Predicts the outputs after the next rising edge and moves the model on.
    task automatic model_push();
        exp_t       e;
        logic [3:0] np [THD_N];
        logic [3:0] nh [THD_N];
        int         c;
        e.rd = {m_psh[bus_if.rd_id_i], m_pop[bus_if.rd_id_i]};
        for (int t = 0; t < THD_N; t++) begin
            np[t] = m_pop[t];
            nh[t] = m_psh[t];
            if (bus_if.clr_i && (int'(bus_if.clr_id_i) == t)) begin
                np[t] = np[t] & ~bus_if.clr_msk_i[3:0];
                nh[t] = nh[t] & ~bus_if.clr_msk_i[7:4];
            end
        end
        np[bus_if.id_2_i] = np[bus_if.id_2_i] | bus_if.pop_er_2_i;
        nh[bus_if.id_6_i] = nh[bus_if.id_6_i] | bus_if.psh_er_6_i;
        for (int t = 0; t < THD_N; t++) begin
            e.irq[t] = bus_if.en_i[t] & ((np[t] != 0) || (nh[t] != 0));
            m_pop[t] = np[t];
            m_psh[t] = nh[t];
        end
        c = $countones(bus_if.pop_er_2_i) + $countones(bus_if.psh_er_6_i);
        if (!bus_if.cnt_clr_i) c = c + int'(m_cnt);
        if (c > 255) c = 255;
        m_cnt = 8'(c);
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    // One clock: predict, then take the edge and compare the registered outputs.
    // The one-cycle strobes return to idle afterwards.
    task automatic cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("rd_data", 32'(bus_if.rd_data_o), 32'(e.rd));
            check("irq", 32'(bus_if.irq_o), 32'(e.irq));
            check("cnt", 32'(bus_if.cnt_o), 32'(e.cnt));
        end
        bus_if.pop_er_2_i = '0;
        bus_if.psh_er_6_i = '0;
        bus_if.clr_i      = 1'b0;
        bus_if.clr_msk_i  = '0;
        bus_if.cnt_clr_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [7:0] cnt_before;

    initial begin
        rst               = 1'b0;
        bus_if.id_2_i     = 3'd0;
        bus_if.pop_er_2_i = 4'hF;
        bus_if.id_6_i     = 3'd0;
        bus_if.psh_er_6_i = 4'h0;
        bus_if.en_i       = 8'h00;
        bus_if.rd_id_i    = 3'd0;
        bus_if.clr_i      = 1'b0;
        bus_if.clr_id_i   = 3'd0;
        bus_if.clr_msk_i  = 8'h00;
        bus_if.cnt_clr_i  = 1'b0;
        model_reset();

        // 1: held in reset with strobes active, then an error on release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", 32'(bus_if.rd_data_o), 32'h0);
        check("rst_irq", 32'(bus_if.irq_o), 32'h0);
        check("rst_cnt", 32'(bus_if.cnt_o), 32'h0);
        rst               = 1'b1;
        bus_if.id_2_i     = 3'd3;
        bus_if.pop_er_2_i = 4'b0010;
        bus_if.en_i       = 8'h08;
        bus_if.rd_id_i    = 3'd3;
        cycle();
        check("t1_irq", 32'(bus_if.irq_o), 32'h08);
        check("t1_cnt", 32'(bus_if.cnt_o), 32'd1);
        cycle();
        check("t1_rd", 32'(bus_if.rd_data_o), 32'h02);

        // 2: both sources hit thread 5 in the same cycle.
        bus_if.en_i       = 8'hFF;
        bus_if.id_2_i     = 3'd5;
        bus_if.id_6_i     = 3'd5;
        bus_if.pop_er_2_i = 4'b0001;
        bus_if.psh_er_6_i = 4'b1000;
        bus_if.rd_id_i    = 3'd5;
        cycle();
        cycle();
        check("t2_rd", 32'(bus_if.rd_data_o), 32'h81);
        check("t2_cnt", 32'(bus_if.cnt_o), 32'd3);

        // 3: clear the flags one at a time. irq falls on the edge of the last clear.
        bus_if.clr_i     = 1'b1;
        bus_if.clr_id_i  = 3'd5;
        bus_if.clr_msk_i = 8'h80;
        cycle();
        cycle();
        check("t3_rd_a", 32'(bus_if.rd_data_o), 32'h01);
        check("t3_irq_a", 32'(bus_if.irq_o[5]), 32'd1);
        bus_if.clr_i     = 1'b1;
        bus_if.clr_msk_i = 8'h01;
        cycle();
        check("t3_irq_b", 32'(bus_if.irq_o[5]), 32'd0);
        cycle();
        check("t3_rd_b", 32'(bus_if.rd_data_o), 32'h00);
        bus_if.clr_i = 1'b1;
        bus_if.clr_id_i = 3'd3;
        bus_if.clr_msk_i = 8'h00;
        bus_if.rd_id_i = 3'd3;
        cycle();
        cycle();
        check("t3_zero_msk", 32'(bus_if.rd_data_o), 32'h02);

        // 4: a set wins over a clear in the same cycle.
        bus_if.id_2_i     = 3'd2;
        bus_if.pop_er_2_i = 4'b0100;
        cycle();
        cnt_before        = m_cnt;
        bus_if.clr_i      = 1'b1;
        bus_if.clr_id_i   = 3'd2;
        bus_if.clr_msk_i  = 8'h04;
        bus_if.pop_er_2_i = 4'b0100;
        bus_if.rd_id_i    = 3'd2;
        cycle();
        check("t4_cnt", 32'(bus_if.cnt_o), 32'(cnt_before + 8'd1));
        cycle();
        check("t4_rd", 32'(bus_if.rd_data_o), 32'h04);

        // Dropping the enable clears the interrupt but leaves the flag set.
        bus_if.en_i    = 8'hF7;
        bus_if.rd_id_i = 3'd3;
        cycle();
        check("en_drop_irq", 32'(bus_if.irq_o[3]), 32'd0);
        cycle();
        check("en_drop_rd", 32'(bus_if.rd_data_o), 32'h02);

        // 5: the counter saturates at the top, and a clear keeps same-cycle events.
        bus_if.cnt_clr_i  = 1'b1;
        bus_if.pop_er_2_i = 4'hF;
        bus_if.psh_er_6_i = 4'hF;
        cycle();
        for (int i = 0; i < 30; i++) begin
            bus_if.pop_er_2_i = 4'hF;
            bus_if.psh_er_6_i = 4'hF;
            cycle();
        end
        bus_if.pop_er_2_i = 4'hF;
        bus_if.psh_er_6_i = 4'h1;
        cycle();
        check("t5_fd", 32'(bus_if.cnt_o), 32'hFD);
        bus_if.pop_er_2_i = 4'hF;
        cycle();
        check("t5_sat", 32'(bus_if.cnt_o), 32'hFF);
        bus_if.pop_er_2_i = 4'hF;
        cycle();
        check("t5_hold", 32'(bus_if.cnt_o), 32'hFF);
        bus_if.cnt_clr_i  = 1'b1;
        bus_if.psh_er_6_i = 4'b0011;
        cycle();
        check("t5_clr", 32'(bus_if.cnt_o), 32'd2);

        // Random traffic, checked against the model.
        for (int i = 0; i < 200; i++) begin
            bus_if.id_2_i     = 3'($urandom);
            bus_if.id_6_i     = 3'($urandom);
            bus_if.pop_er_2_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus_if.psh_er_6_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus_if.rd_id_i    = 3'($urandom);
            bus_if.clr_i      = ($urandom_range(0, 3) == 0);
            bus_if.clr_id_i   = 3'($urandom);
            bus_if.clr_msk_i  = 8'($urandom);
            bus_if.cnt_clr_i  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus_if.en_i = 8'($urandom);
            cycle();
        end

        // 6: an asynchronous reset in mid-stream.
        bus_if.en_i       = 8'hFF;
        bus_if.id_2_i     = 3'd6;
        bus_if.pop_er_2_i = 4'hF;
        bus_if.rd_id_i    = 3'd6;
        cycle();
        cycle();
        check("t6_pre_rd", 32'(bus_if.rd_data_o[3:0]), 32'hF);
        check("t6_pre_irq", 32'(bus_if.irq_o[6]), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_async_rd", 32'(bus_if.rd_data_o), 32'h0);
        check("t6_async_irq", 32'(bus_if.irq_o), 32'h0);
        check("t6_async_cnt", 32'(bus_if.cnt_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        cycle();
        cycle();
        check("t6_post_rd", 32'(bus_if.rd_data_o), 32'h0);
        check("t6_post_irq", 32'(bus_if.irq_o), 32'h0);
        check("t6_post_cnt", 32'(bus_if.cnt_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hive_stack_err.md
Name: hive_stack_err

Overview:
- Downstream consumer of the per-thread stack error strobes from the Hive stack LIFOs.
  - Pop errors arrive at stage 2, tagged with the stage-2 thread ID.
  - Push errors arrive at stage 6, tagged with the stage-6 thread ID.
- Captures errors into sticky per-thread, per-stack flags.
- Keeps a saturating global error event count.
- Drives per-thread interrupt requests.
- Provides a registered readback port and a write-one-to-clear port for the register set.

Parameters:
- THD_W, 3, thread ID width; THD_N = 2**THD_W threads.
- STK_N, 4, number of stacks per thread.
- CNT_W, 8, error event counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- id_2_i  in  THD_W  thread ID at stage 2.
- pop_er_2_i  in  STK_N  pop-when-empty strobes, one per stack, for thread id_2_i.
- id_6_i  in  THD_W  thread ID at stage 6.
- psh_er_6_i  in  STK_N  push-when-full strobes, one per stack, for thread id_6_i.
- en_i  in  THD_N  per-thread interrupt enable.
- rd_id_i  in  THD_W  readback thread select.
- rd_data_o  out  2*STK_N  readback {psh flags, pop flags} of the selected thread.
- clr_i  in  1  clear strobe.
- clr_id_i  in  THD_W  thread to clear.
- clr_msk_i  in  2*STK_N  write-one-to-clear mask, {psh, pop} layout.
- cnt_clr_i  in  1  error counter clear strobe.
- cnt_o  out  CNT_W  saturating count of error events.
- irq_o  out  THD_N  per-thread interrupt request.

Behaviour:
- Reset (rst_i low, asynchronous): clears all flags, rd_data_o, cnt_o and irq_o to 0. Release is synchronous to clk_i. An error strobe present in the release cycle is captured at the first rising edge with rst_i high.
- State:
  - pop_flg[THD_N][STK_N] and psh_flg[THD_N][STK_N], sticky.
  - Next-state flg_d computed combinationally each cycle.
- Set: flg_d.pop[id_2_i] |= pop_er_2_i and flg_d.psh[id_6_i] |= psh_er_6_i, applied at the rising edge.
  - Both sources may hit the same thread in the same cycle (id_2_i == id_6_i); both sets apply.
- Clear (clr_i high): flags of clr_id_i with clr_msk_i bit = 1 are cleared at the edge. Mask bits = 0 are untouched.
- Set beats clear: if a bit is cleared and set in the same cycle, it ends at 1.
- clr_i with an all-zero mask is a no-op.
- Readback: rd_data_o <= {psh_flg[rd_id_i], pop_flg[rd_id_i]}, sampled from the flag register, not from flg_d.
  - Latency 1 cycle from rd_id_i.
  - An error captured at edge N is visible on rd_data_o after edge N+1 when selected.
- Interrupt: irq_o[t] <= en_i[t] & |{psh_flg_d[t], pop_flg_d[t]}.
  - Asserts on the same edge the flag sets.
  - Deasserts on the edge that clears the last flag of t, or when en_i[t] drops.
  - Level output; flags remain sticky regardless of en_i.
- Counter:
  - inc = popcount(pop_er_2_i) + popcount(psh_er_6_i); range 0..2*STK_N, computed at width CNT_W+1.
  - cnt_clr_i low: cnt_o <= min(cnt_o + inc, 2**CNT_W - 1).
  - cnt_clr_i high: cnt_o <= min(inc, 2**CNT_W - 1), so same-cycle events are never lost.
  - No wrap-around; the counter holds at all-ones until cleared.
  - Repeated errors on already-set flags still count.
- No combinational path from any input to any output.

Test Plan:
1. Reset low with pop_er_2_i = 4'hF -> all outputs 0. Release, then id_2_i = 3, pop_er_2_i = 4'b0010, en_i = 8'h08 -> irq_o = 8'h08 after that edge. rd_id_i = 3 -> rd_data_o = 8'h02 one cycle later. cnt_o = 1.
2. id_2_i = id_6_i = 5, pop_er_2_i = 4'b0001, psh_er_6_i = 4'b1000 in the same cycle -> rd_data_o(thread 5) = 8'h81, cnt_o += 2.
3. Thread 5 flags 8'h81. clr_i, clr_id_i = 5, clr_msk_i = 8'h80 -> 8'h01, irq_o[5] stays 1. Second clear with mask 8'h01 -> 8'h00, irq_o[5] = 0 on the same edge.
4. clr_i with clr_id_i = 2, mask 8'h04, concurrent with id_2_i = 2, pop_er_2_i = 4'b0100 -> bit stays 1 (set wins), cnt_o increments.
5. CNT_W = 8, cnt_o = 8'hFD, pop_er_2_i = 4'hF -> cnt_o = 8'hFF and holds. cnt_clr_i with psh_er_6_i = 4'b0011 -> cnt_o = 2.
6. Assert rst_i low mid-stream with flags set and irq_o active -> outputs drop to 0 asynchronously without a clock edge. Sticky state is gone after release.
